// File: rtl/div_seq_pkg.sv
// Shared encodings and constants for the sequential radix-2 restoring divider.
package div_seq_pkg;

  localparam int DIV_ITER = 32;

  localparam logic DIV_SIGNED   = 1'b1;
  localparam logic DIV_UNSIGNED = 1'b0;

  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_END    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_seq.sv
// Multi-cycle restoring divider for the execute stage; result is {remainder, quotient}.
// Start must stay high until ready_o; dropping it or raising annul_i abandons the operation.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_ITER
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH + 1);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH:0]     work_q, work_d;
  logic [WIDTH-1:0]     dvsr_q, dvsr_d;
  logic                 sdiv_q, sdiv_d;
  logic                 sgn1_q, sgn1_d;
  logic                 sgn2_q, sgn2_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 ready_q, ready_d;

  logic                 abort;
  logic [2*WIDTH:0]     shifted, step;
  logic [WIDTH+1:0]     diff;
  logic [WIDTH-1:0]     abs1, abs2, quot, rem;

  assign abort = annul_i | ~start_i;

  // Operand magnitudes; negating the most negative value yields itself,
  // which is the correct unsigned magnitude.
  assign abs1 = (signed_div_i == DIV_SIGNED && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i == DIV_SIGNED && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

  // One trial-subtract step: a borrow out of the upper bits means restore.
  always_comb begin
    shifted = work_q << 1;
    diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, dvsr_q};
    if (diff[WIDTH+1]) step = shifted;
    else               step = {diff[WIDTH:0], shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1}};
  end

  assign quot = (sdiv_q && (sgn1_q ^ sgn2_q)) ? -work_q[WIDTH-1:0] : work_q[WIDTH-1:0];
  assign rem  = (sdiv_q && sgn1_q) ? -work_q[2*WIDTH-1:WIDTH] : work_q[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      dvsr_q   <= '0;
      sdiv_q   <= 1'b0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      dvsr_q   <= dvsr_d;
      sdiv_q   <= sdiv_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: begin
        if (annul_i)                        state_d = DIV_IDLE;
        else if (start_i && opdata2_i == '0) state_d = DIV_BYZERO;
        else if (start_i)                   state_d = DIV_ON;
      end
      DIV_BYZERO: state_d = abort ? DIV_IDLE : DIV_END;
      DIV_ON: begin
        if (abort)                        state_d = DIV_IDLE;
        else if (cnt_q == CW'(WIDTH))     state_d = DIV_END;
      end
      DIV_END:    state_d = abort ? DIV_IDLE : DIV_END;
      default:    state_d = DIV_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = cnt_q;
    work_d   = work_q;
    dvsr_d   = dvsr_q;
    sdiv_d   = sdiv_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;
    ready_d  = 1'b0;
    case (state_q)
      DIV_IDLE: begin
        result_d = '0;
        cnt_d    = '0;
        if (state_d == DIV_ON) begin
          work_d = {{(WIDTH+1){1'b0}}, abs1};
          dvsr_d = abs2;
          sdiv_d = signed_div_i;
          sgn1_d = opdata1_i[WIDTH-1];
          sgn2_d = opdata2_i[WIDTH-1];
        end
      end
      DIV_BYZERO: begin
        result_d = '0;
        ready_d  = (state_d == DIV_END);
      end
      DIV_ON: begin
        if (state_d == DIV_IDLE) begin
          result_d = '0;
        end else if (cnt_q != CW'(WIDTH)) begin
          work_d = step;
          cnt_d  = cnt_q + CW'(1);
        end else begin
          result_d = {rem, quot};
          ready_d  = 1'b1;
        end
      end
      DIV_END: begin
        if (state_d == DIV_IDLE) result_d = '0;
        else                     ready_d  = 1'b1;
      end
      default: result_d = '0;
    endcase
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
